// File: rtl/set_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | set_bus_pkg                                                          |
// | Shared widths, FSM states and grant encoding for the set-bus arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package set_bus_pkg;

  localparam int unsigned SB_AW     = 16;
  localparam int unsigned SB_DW     = 16;
  localparam int unsigned SB_RD_LAT = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  typedef enum logic {
    GNT_A = 1'b0,
    GNT_B = 1'b1
  } grant_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/set_a_capture.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | set_a_capture                                                        |
// | One-deep holding register for port A strobes plus overflow counter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module set_a_capture
  import set_bus_pkg::*;
#(
  parameter int AW = SB_AW,
  parameter int DW = SB_DW
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          a_wr_en,
  input  logic [AW-1:0] a_wr_addr,
  input  logic [DW-1:0] a_wr_data,
  input  logic          a_rd_en,
  input  logic [AW-1:0] a_rd_addr,
  input  logic          grant_a,
  output logic          pend,
  output logic          pend_we,
  output logic [AW-1:0] pend_addr,
  output logic [DW-1:0] pend_data,
  output logic [7:0]    ovf_cnt
);

  logic          pend_q, pend_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic [7:0]    ovf_q, ovf_d;
  logic          strobe;
  logic          accept;

  always_comb begin
    strobe = a_wr_en | a_rd_en;
    // A slot being granted this cycle frees up in time for a new strobe.
    accept = ~pend_q | grant_a;
    pend_d = pend_q;
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    ovf_d  = ovf_q;
    if (grant_a) begin
      pend_d = 1'b0;
    end
    if (strobe && accept) begin
      pend_d = 1'b1;
      we_d   = a_wr_en;
      addr_d = a_wr_en ? a_wr_addr : a_rd_addr;
      data_d = a_wr_en ? a_wr_data : data_q;
    end
    if ((strobe && !accept) || (a_wr_en && a_rd_en)) begin
      ovf_d = sat_inc8(ovf_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pend_q <= 1'b0;
      we_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ovf_q  <= 8'd0;
    end else begin
      pend_q <= pend_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ovf_q  <= ovf_d;
    end
  end

  assign pend      = pend_q;
  assign pend_we   = we_q;
  assign pend_addr = addr_q;
  assign pend_data = data_q;
  assign ovf_cnt   = ovf_q;

endmodule
`default_nettype wire

// File: rtl/set_bus_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | set_bus_arbiter                                                      |
// | Round-robin sharing of the settings bus between SPI strobes (A) and  |
// | a local req/ack master (B), one access at a time. Rev 1.0            |
// +----------------------------------------------------------------------+
module set_bus_arbiter
  import set_bus_pkg::*;
#(
  parameter int AW     = SB_AW,
  parameter int DW     = SB_DW,
  parameter int RD_LAT = SB_RD_LAT
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          a_wr_en,
  input  logic [AW-1:0] a_wr_addr,
  input  logic [DW-1:0] a_wr_data,
  input  logic          a_rd_en,
  input  logic [AW-1:0] a_rd_addr,
  output logic [DW-1:0] a_rd_data,
  output logic          a_rd_valid,
  input  logic          b_req,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_ack,
  output logic [DW-1:0] b_rdata,
  output logic          b_rvalid,
  output logic          m_wr_en,
  output logic [AW-1:0] m_wr_addr,
  output logic [DW-1:0] m_wr_data,
  output logic          m_rd_en,
  output logic [AW-1:0] m_rd_addr,
  input  logic [DW-1:0] m_rd_data,
  output logic [7:0]    ovf_cnt
);

  localparam logic [2:0] LAT_C = 3'(RD_LAT);

  state_e        state_q, state_d;
  grant_e        last_q, last_d;
  grant_e        gnt_q, gnt_d;
  grant_e        sel;
  logic [2:0]    lat_q, lat_d;
  logic          m_wr_en_q, m_wr_en_d;
  logic          m_rd_en_q, m_rd_en_d;
  logic [AW-1:0] m_wr_addr_q, m_wr_addr_d;
  logic [DW-1:0] m_wr_data_q, m_wr_data_d;
  logic [AW-1:0] m_rd_addr_q, m_rd_addr_d;
  logic          b_ack_q, b_ack_d;
  logic [DW-1:0] a_rd_data_q, a_rd_data_d;
  logic [DW-1:0] b_rdata_q, b_rdata_d;

  logic          grant_a;
  logic          rd_done;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_data;

  logic          a_pend;
  logic          a_pend_we;
  logic [AW-1:0] a_pend_addr;
  logic [DW-1:0] a_pend_data;

  set_a_capture #(
    .AW (AW),
    .DW (DW)
  ) u_a_capture (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .a_wr_en   (a_wr_en),
    .a_wr_addr (a_wr_addr),
    .a_wr_data (a_wr_data),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .grant_a   (grant_a),
    .pend      (a_pend),
    .pend_we   (a_pend_we),
    .pend_addr (a_pend_addr),
    .pend_data (a_pend_data),
    .ovf_cnt   (ovf_cnt)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    lat_d       = lat_q;
    m_wr_en_d   = 1'b0;
    m_rd_en_d   = 1'b0;
    m_wr_addr_d = m_wr_addr_q;
    m_wr_data_d = m_wr_data_q;
    m_rd_addr_d = m_rd_addr_q;
    b_ack_d     = 1'b0;
    sel         = GNT_A;
    grant_a     = 1'b0;
    rd_done     = 1'b0;
    req_we      = a_pend_we;
    req_addr    = a_pend_addr;
    req_data    = a_pend_data;
    case (state_q)
      IDLE: begin
        if (a_pend || b_req) begin
          if (a_pend && b_req) begin
            sel = (last_q == GNT_B) ? GNT_A : GNT_B;
          end else begin
            sel = a_pend ? GNT_A : GNT_B;
          end
          if (sel == GNT_B) begin
            req_we   = b_we;
            req_addr = b_addr;
            req_data = b_wdata;
          end
          grant_a = (sel == GNT_A);
          gnt_d   = sel;
          last_d  = sel;
          b_ack_d = (sel == GNT_B);
          if (req_we) begin
            m_wr_en_d   = 1'b1;
            m_wr_addr_d = req_addr;
            m_wr_data_d = req_data;
          end else begin
            m_rd_en_d   = 1'b1;
            m_rd_addr_d = req_addr;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (m_rd_en_q) begin
          lat_d   = 3'd1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        // Final WAIT cycle is the one in which the register file data is valid.
        if (lat_q == LAT_C) begin
          rd_done = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data is forwarded in the completion cycle and held in a register after.
  assign a_rd_valid  = rd_done & (gnt_q == GNT_A) & ~reset_i;
  assign b_rvalid    = rd_done & (gnt_q == GNT_B) & ~reset_i;
  assign a_rd_data_d = a_rd_valid ? m_rd_data : a_rd_data_q;
  assign b_rdata_d   = b_rvalid ? m_rd_data : b_rdata_q;
  assign a_rd_data   = a_rd_data_d;
  assign b_rdata     = b_rdata_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      last_q      <= GNT_B;
      gnt_q       <= GNT_A;
      lat_q       <= 3'd0;
      m_wr_en_q   <= 1'b0;
      m_rd_en_q   <= 1'b0;
      m_wr_addr_q <= '0;
      m_wr_data_q <= '0;
      m_rd_addr_q <= '0;
      b_ack_q     <= 1'b0;
      a_rd_data_q <= '0;
      b_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      lat_q       <= lat_d;
      m_wr_en_q   <= m_wr_en_d;
      m_rd_en_q   <= m_rd_en_d;
      m_wr_addr_q <= m_wr_addr_d;
      m_wr_data_q <= m_wr_data_d;
      m_rd_addr_q <= m_rd_addr_d;
      b_ack_q     <= b_ack_d;
      a_rd_data_q <= a_rd_data_d;
      b_rdata_q   <= b_rdata_d;
    end
  end

  assign m_wr_en   = m_wr_en_q;
  assign m_rd_en   = m_rd_en_q;
  assign m_wr_addr = m_wr_addr_q;
  assign m_wr_data = m_wr_data_q;
  assign m_rd_addr = m_rd_addr_q;
  assign b_ack     = b_ack_q;

endmodule
`default_nettype wire
